bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter using reverse double dabble. It is the decode partner of the team's binary-to-BCD shift-and-add-3 register.
- Each step shifts a combined {BCD, binary} scratch register right by one bit. Every BCD nibble that is 8 or more then has 3 subtracted.
- After BIN_W steps the low field holds the binary value.
- Used on the keypad/display path to turn entered decimal digits back into an operand.

Parameters:
- NDIG, 3, number of BCD digits on bcd_in (input width 4*NDIG).
- BIN_W, 10, binary result width; must satisfy 2^BIN_W > 10^NDIG - 1.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- bcd_in  input  4*NDIG  packed BCD, digit 0 in [3:0]; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bin_out and err are valid while high and held until the next accept.
- err  output  1  set with done if any input nibble was > 9.
- bin_out  output  BIN_W  converted value.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low on rstn: sampled only at the rising edge of clk.
  - Reset values: busy=0, done=0, err=0, bin_out=0, state=IDLE, step counter=0, scratch=0.
  - Reset overrides everything, including mid-conversion. That conversion is abandoned and no done is produced.
- State machine, IDLE / RUN:
  - IDLE, start=1 at edge k (the accepting edge):
    - scratch <= {bcd_in, BIN_W'b0}; cnt <= 0; state <= RUN; busy <= 1.
    - err_pending <= OR over digits of (nibble > 9).
    - done <= 0 and err <= 0 (cleared on accept).
  - RUN, each edge: perform one step on scratch and increment cnt.
    - Step: shift the whole scratch right by 1 with 0 into the MSB. Then, on the shifted value, each BCD nibble >= 8 becomes nibble - 3 (4-bit, no borrow between digits).
  - RUN, step where cnt == BIN_W-1 (edge k+BIN_W):
    - bin_out <= err_pending ? 0 : low BIN_W bits of the stepped scratch.
    - err <= err_pending; done <= 1; busy <= 0; state <= IDLE.
- Latency: done is high in the cycle following edge k+BIN_W, i.e. BIN_W cycles after the accepting edge. Latency is fixed, including the error case.
- done is high for exactly one cycle. bin_out and err hold until the next accept.
- start while busy=1 is ignored, not queued. bcd_in changes during RUN have no effect.
- start=1 in the cycle where done=1 is accepted (state is already IDLE): back-to-back throughput of one result per BIN_W+1... edges. done drops on that accepting edge.
- Arithmetic: the adjust never underflows for valid input. For invalid input the nibble arithmetic is modulo 16, and the result is discarded and forced to 0.
- Holding start high continuously produces a conversion every BIN_W+1 cycles.

Decomposition:
- Shared package holds:
  - localparam DIGIT_W = 4.
  - ADJ_THRESH = 4'd8 and ADJ_SUB = 4'd3.
  - MAX_DIGIT = 4'd9.
  - State enum {IDLE, RUN}, 1 bit.
  - Function clog2 for the cnt width.
- One natural sub-module: bcd_digit_sub3. It is combinational, 4-bit in / 4-bit out, subtracting 3 when the input is >= 8, and is instantiated NDIG times in a generate loop.
- The top holds the FSM, counter, scratch register and output registers.

Test Plan:
- Reset, then bcd_in=12'h000 and start -> done exactly 10 cycles after accept, bin_out=10'd0, err=0.
- bcd_in=12'h999, start -> bin_out=10'h3E7 (999), err=0. Also 12'h255 -> 10'h0FF, and 12'h100 -> 10'd100.
- bcd_in=12'h1A3 (invalid middle digit) -> done at the same latency, err=1, bin_out=0. A following valid start clears err at accept.
- start pulsed again at cycles 3 and 7 of a conversion -> ignored: exactly one done, result unchanged. Then start asserted in the done cycle -> second conversion accepted, second done 10 cycles later.
- rstn=0 for one edge at cycle 5 of a conversion of 12'h512 -> busy=0 and all outputs 0 next cycle, no done ever; a new start converts 12'h512 -> 10'd512.
- Randomised sweep 0..999 against a reference model -> bin_out matches and latency is constant at BIN_W.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared constants, state encoding and width helper for the BCD-to-binary converter.
package bcd_to_bin_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to count 0..v-1; never less than one.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle between the keypad path and the BCD-to-binary converter.
interface bcd_to_bin_if
  import bcd_to_bin_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) ();

  logic                      start;
  logic [DIGIT_W*NDIG-1:0]   bcd_in;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [BIN_W-1:0]          bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd_to_bin_sub3.sv
// Per-digit reverse double-dabble adjust: combinational, nibbles >= 8 lose 3 (mod 16).
// No state, no backpressure.
module bcd_digit_sub3
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= ADJ_THRESH) ? (d - ADJ_SUB) : d;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble); done pulses BIN_W cycles after accept.
// No backpressure: start is only sampled in IDLE, requests while busy are dropped.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic         clk,
  input  logic         rstn,
  bcd_to_bin_if.slave  bus
);

  localparam int BCD_W = DIGIT_W * NDIG;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SCR_W-1:0]   scratch;
  logic               err_pending;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [BIN_W-1:0]   bin_q;

  logic [SCR_W-1:0]   shifted;
  logic [SCR_W-1:0]   stepped;
  logic               err_in;

  assign shifted = scratch >> 1;
  assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

  // Adjust is applied after the shift, on the BCD field only.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_sub3 u_sub3 (
      .d (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .q (stepped[BIN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) err_in = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      scratch     <= '0;
      err_pending <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bin_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            scratch     <= {bus.bcd_in, {BIN_W{1'b0}}};
            cnt         <= '0;
            state       <= RUN;
            busy_q      <= 1'b1;
            err_pending <= err_in;
            err_q       <= 1'b0;
          end
        end
        RUN: begin
          scratch <= stepped;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            // Invalid digits still take the full step count so latency never varies.
            bin_q  <= err_pending ? '0 : stepped[BIN_W-1:0];
            err_q  <= err_pending;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Randomised self-checking bench for bcd_to_bin against a decimal reference model.
module tb_bcd_to_bin;

  localparam int NDIG  = 3;
  localparam int BIN_W = 10;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  bcd_to_bin_if #(.NDIG(NDIG), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal meaning of the packed digits; any non-decimal digit flags an error and forces 0.
  task automatic ref_model(input logic [11:0] bcd, output int val, output bit bad);
    logic [11:0] b;
    int d;
    b = bcd;
    val = 0;
    bad = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = int'(b[i*4 +: 4]);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) val = 0;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called #1 after an edge: asserts start, optionally re-pulses start mid-run, waits for done.
  task automatic convert(input logic [11:0] bcd, input int pa, input int pb);
    int  lat;
    int  exp_val;
    bit  exp_err;
    ref_model(bcd, exp_val, exp_err);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = 12'($urandom);
    chk("busy_at_accept", 32'(bus.busy), 32'd1);
    chk("done_cleared_at_accept", 32'(bus.done), 32'd0);
    chk("err_cleared_at_accept", 32'(bus.err), 32'd0);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      bus.start = (lat == pa || lat == pb);
      if (bus.start) bus.bcd_in = 12'h999;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(BIN_W));
    chk("bin_out", 32'(bus.bin_out), 32'(exp_val));
    chk("err", 32'(bus.err), 32'(exp_err));
    chk("busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic idle_hold(input int n, input int exp_val, input bit exp_err);
    int ndone;
    ndone = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("no_extra_done", 32'(ndone), 32'd0);
    chk("bin_out_held", 32'(bus.bin_out), 32'(exp_val));
    chk("err_held", 32'(bus.err), 32'(exp_err));
  endtask

  initial begin
    int   ndone;
    int   v;
    logic [11:0] b;
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.bcd_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    convert(12'h000, -1, -1);
    idle_hold(3, 0, 1'b0);
    convert(12'h999, -1, -1);
    convert(12'h255, -1, -1);
    convert(12'h100, -1, -1);
    convert(12'h1A3, -1, -1);
    idle_hold(2, 0, 1'b1);
    convert(12'h042, -1, -1);

    // Mid-run start pulses are dropped; start in the done cycle chains immediately.
    convert(12'h123, 3, 7);
    convert(12'h456, -1, -1);
    idle_hold(12, 456, 1'b0);

    // Reset in the middle of a conversion abandons it.
    bus.start  = 1'b1;
    bus.bcd_in = 12'h512;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    chk("midrst_bin_out", 32'(bus.bin_out), 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    convert(12'h512, -1, -1);

    // Random sweep, with occasional corrupted digits and back-to-back requests.
    for (int n = 0; n < 60; n++) begin
      v = int'($urandom_range(0, 999));
      b = to_bcd(v);
      if ($urandom_range(0, 7) == 0) b[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
      convert(b, -1, -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
